// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a reloadable pattern, input qualifier,
// overlap/non-overlap matching and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              match;

  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], in};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match  = 1'b0;
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    // A load restarts the fill count, so a bit presented alongside it is dropped.
    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_n;
      fill_d = fill_n;
      match  = (hist_n == pat_q) && (fill_n == FILL_FULL);
      if (match && (OVERLAP == 0)) begin
        fill_d = '0;
      end
    end

    out_d = match;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlapping, non-overlapping and
// 2-bit-counter instances share one stimulus stream.
module tb_seq_detector_param;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       in_bit;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       out_d, out_n, out_c;
  logic [7:0] cnt_def, cnt_nov;
  logic [1:0] cnt_c2;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detector_param u_def (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out_d), .match_cnt(cnt_def)
  );

  seq_detector_param #(.OVERLAP(0)) u_nov (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out_n), .match_cnt(cnt_nov)
  );

  seq_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(in_bit),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out_c), .match_cnt(cnt_c2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       v;
    logic       b;
    logic       ld;
    logic [3:0] pat;
    logic       clr;
    logic       eo_def;
    logic [7:0] ec_def;
    logic       eo_nov;
    logic [7:0] ec_nov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic b, input logic ld,
                     input logic [3:0] pat, input logic clr,
                     input logic eod, input logic [7:0] ecd,
                     input logic eon, input logic [7:0] ecn);
    vec_t t;
    t = '{r, v, b, ld, pat, clr, eod, ecd, eon, ecn};
    vecs.push_back(t);
  endtask

  // Driver: apply inputs, let one posedge sample them, settle past the edge.
  task automatic step(input logic r, input logic v, input logic b, input logic ld,
                      input logic [3:0] pat, input logic clr);
    rstn = r; in_valid = v; in_bit = b; pat_load = ld; pat_in = pat; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [15:0] c2_bits;
    logic [15:0] c2_hits;
    int          hits;

    rstn = 1'b0; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
    pat_in = 4'b0; cnt_clr = 1'b0;

    //   rstn v  b  ld pat      clr  out_d cnt_d out_n cnt_n
    add(0, 0, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    // stream 1,0,1,1,0,1,1
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 1, 1, 1);
    add(1, 1, 0, 0, 4'b0000, 0,  0, 1, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 2, 0, 1);
    // load 1111 with a dropped bit, then six 1s
    add(1, 1, 0, 1, 4'b1111, 0,  0, 2, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 2, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 2, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 2, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 3, 1, 2);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 4, 0, 2);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 5, 0, 2);
    // clear, reload 1011, bits 1,0,1, five idle cycles with in toggling, then 1
    add(1, 0, 0, 0, 4'b0000, 1,  0, 0, 0, 0);
    add(1, 0, 0, 1, 4'b1011, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 0, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 0, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 0, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 1, 1, 1);
    // cnt_clr coincident with an overlapping match
    add(1, 1, 0, 0, 4'b0000, 0,  0, 1, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 1, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 1,  1, 0, 0, 0);
    // reset mid-stream discards partial history
    add(0, 0, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(0, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  0, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 0,  1, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rstn, vecs[i].v, vecs[i].b, vecs[i].ld, vecs[i].pat, vecs[i].clr);
      check("out_ovl", i, {7'b0, out_d}, {7'b0, vecs[i].eo_def});
      check("cnt_ovl", i, cnt_def, vecs[i].ec_def);
      check("out_novl", i, {7'b0, out_n}, {7'b0, vecs[i].eo_nov});
      check("cnt_novl", i, cnt_nov, vecs[i].ec_nov);
    end

    // CNT_W=2: five overlapping matches saturate the counter at 3
    step(0, 0, 0, 0, 4'b0000, 0);
    check("c2_reset_cnt", 0, {6'b0, cnt_c2}, 8'd0);
    c2_bits = 16'b1011011011011011;
    c2_hits = 16'b0001001001001001;
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1, c2_bits[15-i], 0, 4'b0000, 0);
      if (c2_hits[15-i]) hits++;
      check("c2_out", i, {7'b0, out_c}, {7'b0, c2_hits[15-i]});
      check("c2_cnt", i, {6'b0, cnt_c2}, (hits > 3) ? 8'd3 : 8'(hits));
    end
    // cnt_clr wins over a same-cycle match; out still pulses
    step(1, 1, 0, 0, 4'b0000, 0);
    step(1, 1, 1, 0, 4'b0000, 0);
    step(1, 1, 1, 0, 4'b0000, 1);
    check("c2_clr_out", 0, {7'b0, out_c}, 8'd1);
    check("c2_clr_cnt", 0, {6'b0, cnt_c2}, 8'd0);

    // All-zero pattern needs four real zeros after the load
    step(0, 0, 0, 0, 4'b0000, 0);
    step(1, 0, 0, 1, 4'b0000, 0);
    check("zero_pat_load", 0, {7'b0, out_d}, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0, 0, 4'b0000, 0);
      check("zero_pat_out", i, {7'b0, out_d}, (i == 4) ? 8'd1 : 8'd0);
    end
    // Strobe lasts one cycle
    step(1, 0, 0, 0, 4'b0000, 0);
    check("zero_pat_strobe_end", 0, {7'b0, out_d}, 8'd0);
    check("zero_pat_cnt", 0, cnt_def, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
